// File: rtl/seq_playback_pkg.sv
// Shared types and constants for the sequence playback path.
package seq_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, GAP, FIN} seq_play_t;

  // Number of steps in a stored sequence; also used by the storage block.
  localparam int SEQ_LEN = 8;

  // Width of the step index output (covers up to 8 steps).
  localparam int STEP_W = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_playback_if.sv
// Handshake and data bundle between the game controller and playback block.
interface seq_playback_if #(
  parameter int SEQ_LEN = seq_pkg::SEQ_LEN
);
  import seq_pkg::*;

  logic               START;
  logic [SEQ_LEN-1:0] SEQ;
  logic [SEQ_LEN-1:0] LEDS;
  logic [STEP_W-1:0]  STEP;
  logic               BUSY;
  logic               DONE;

  modport master (output START, SEQ, input LEDS, STEP, BUSY, DONE);
  modport slave  (input START, SEQ, output LEDS, STEP, BUSY, DONE);

endinterface

// File: rtl/seq_playback_step_timer.sv
// Down-counter that is loaded with (ticks-1) and flags expiry when it hits zero.
module step_timer #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/seq_playback.sv
// Plays a stored button sequence on the LEDs, one step at a time, with an
// optional dark gap between steps. Outputs are registered from next-state.
module seq_playback
  import seq_pkg::*;
#(
  parameter int SEQ_LEN    = seq_pkg::SEQ_LEN,
  parameter int STEP_TICKS = 50_000_000,
  parameter int GAP_TICKS  = 10_000_000
) (
  input  logic          CLK,
  input  logic          RST_N,
  seq_playback_if.slave bus
);

  localparam int TW = $clog2(max_int(STEP_TICKS, GAP_TICKS) + 1);
  localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_TICKS - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SEQ_LEN - 1);

  seq_play_t          state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [SEQ_LEN-1:0] shadow_q, shadow_d;
  logic [SEQ_LEN-1:0] leds_q;
  logic               busy_q;
  logic               done_q;
  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_expire;

  // One-hot LED for the given step, lit only when that step's bit is set.
  function automatic logic [SEQ_LEN-1:0] led_pattern(
    input logic [SEQ_LEN-1:0] pat,
    input logic [STEP_W-1:0]  idx
  );
    logic [SEQ_LEN-1:0] r;
    r = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (idx == STEP_W'(i)) r[i] = pat[i];
    end
    return r;
  endfunction

  step_timer #(.W(TW)) u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Next-state, step index, shadow capture and timer reload decisions.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    shadow_d = shadow_q;
    tmr_load = 1'b0;
    tmr_val  = STEP_LOAD;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          shadow_d = bus.SEQ;
          step_d   = '0;
          tmr_load = 1'b1;
          tmr_val  = STEP_LOAD;
          state_d  = SHOW;
        end
      end
      SHOW: begin
        if (tmr_expire) begin
          if (GAP_TICKS > 0) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
            state_d  = GAP;
          end else if (step_q == LAST_STEP) begin
            state_d = FIN;
          end else begin
            step_d   = step_q + STEP_W'(1);
            tmr_load = 1'b1;
            tmr_val  = STEP_LOAD;
          end
        end
      end
      GAP: begin
        if (tmr_expire) begin
          if (step_q == LAST_STEP) begin
            state_d = FIN;
          end else begin
            step_d   = step_q + STEP_W'(1);
            tmr_load = 1'b1;
            tmr_val  = STEP_LOAD;
            state_d  = SHOW;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, step and shadow registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      step_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      shadow_q <= shadow_d;
    end
  end

  // Registered outputs derived from next-state so they align with the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      leds_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      leds_q <= (state_d == SHOW) ? led_pattern(shadow_d, step_d) : '0;
      busy_q <= (state_d == SHOW) || (state_d == GAP);
      done_q <= (state_d == FIN);
    end
  end

  assign bus.LEDS = leds_q;
  assign bus.STEP = step_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_seq_playback.sv
// Directed bench for seq_playback: one instance with a gap, one without.
module tb_seq_playback;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_playback_if #(.SEQ_LEN(8)) ifa ();
  seq_playback_if #(.SEQ_LEN(8)) ifb ();

  seq_playback #(.SEQ_LEN(8), .STEP_TICKS(4), .GAP_TICKS(2)) dut_a (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (ifa)
  );

  seq_playback #(.SEQ_LEN(8), .STEP_TICKS(4), .GAP_TICKS(0)) dut_b (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d got=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) ifb.START = v;
    else     ifa.START = v;
  endtask

  task automatic set_seq(input bit sel, input logic [7:0] v);
    if (sel) ifb.SEQ = v;
    else     ifa.SEQ = v;
  endtask

  task automatic get_obs(input bit sel, output logic [7:0] l, output logic [2:0] s,
                         output logic b, output logic d);
    if (sel) begin
      l = ifb.LEDS; s = ifb.STEP; b = ifb.BUSY; d = ifb.DONE;
    end else begin
      l = ifa.LEDS; s = ifa.STEP; b = ifa.BUSY; d = ifa.DONE;
    end
  endtask

  // Expected outputs n cycles after the START edge (STEP_TICKS=4).
  function automatic void model(input int n, input logic [7:0] pat, input int gap,
                                output logic [7:0] l, output logic [2:0] s,
                                output logic b, output logic d);
    int per;
    int total;
    int st;
    int ph;
    per   = 4 + gap;
    total = 8 * per;
    if (n < total) begin
      st = n / per;
      ph = n % per;
      s  = 3'(st);
      b  = 1'b1;
      d  = 1'b0;
      l  = (ph < 4 && pat[st]) ? 8'(1 << st) : 8'h00;
    end else begin
      s = 3'd7;
      b = 1'b0;
      d = (n == total);
      l = 8'h00;
    end
  endfunction

  task automatic check_all(input string tag, input bit sel, input int n,
                           input logic [7:0] el, input logic [2:0] es,
                           input logic eb, input logic ed);
    logic [7:0] l;
    logic [2:0] s;
    logic       b;
    logic       d;
    get_obs(sel, l, s, b, d);
    check({tag, "_leds"}, n, 32'(l), 32'(el));
    check({tag, "_step"}, n, 32'(s), 32'(es));
    check({tag, "_busy"}, n, 32'(b), 32'(eb));
    check({tag, "_done"}, n, 32'(d), 32'(ed));
  endtask

  // Start a playback and check every cycle through the following IDLE cycle.
  task automatic play(input string tag, input bit sel, input logic [7:0] pat, input int gap,
                      input bit hold, input bit disturb, input int runs);
    int per;
    logic [7:0] el;
    logic [2:0] es;
    logic       eb;
    logic       ed;
    per = 8 * (4 + gap) + 2;
    set_seq(sel, pat);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_start(sel, 1'b0);
    for (int n = 0; n < runs * per; n++) begin
      @(negedge clk);
      model(n % per, pat, gap, el, es, eb, ed);
      check_all(tag, sel, n, el, es, eb, ed);
      if (disturb && n == 10) begin
        set_seq(sel, 8'hFF);
        set_start(sel, 1'b1);
      end
      if (disturb && n == 11) set_start(sel, 1'b0);
    end
    set_start(sel, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ifa.START = 1'b0;
    ifa.SEQ   = 8'h00;
    ifb.START = 1'b0;
    ifb.SEQ   = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: everything stays dark and quiet.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_all("idle_a", 1'b0, i, 8'h00, 3'd0, 1'b0, 1'b0);
      check_all("idle_b", 1'b1, i, 8'h00, 3'd0, 1'b0, 1'b0);
    end

    // Pattern A5 with a SEQ change and a stray START mid-playback.
    play("pat_a5", 1'b0, 8'hA5, 2, 1'b0, 1'b1, 1);

    // No gap: LEDs walk 01..80 back to back, DONE after 32 cycles.
    play("nogap_ff", 1'b1, 8'hFF, 0, 1'b0, 1'b0, 1);

    // Asynchronous reset in the middle of cycle 15 of a playback.
    begin
      logic [7:0] l;
      logic [2:0] s;
      logic       b;
      logic       d;
      set_seq(1'b0, 8'hA5);
      set_start(1'b0, 1'b1);
      @(posedge clk);
      #1;
      set_start(1'b0, 1'b0);
      repeat (16) @(negedge clk);
      check_all("pre_rst", 1'b0, 15, 8'h04, 3'd2, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      get_obs(1'b0, l, s, b, d);
      check("rst_async_leds", 15, 32'(l), 32'h0);
      check("rst_async_step", 15, 32'(s), 32'h0);
      check("rst_async_busy", 15, 32'(b), 32'h0);
      check("rst_async_done", 15, 32'(d), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check_all("post_rst", 1'b0, i, 8'h00, 3'd0, 1'b0, 1'b0);
      end
    end
    play("replay_a5", 1'b0, 8'hA5, 2, 1'b0, 1'b0, 1);

    // START held high: two playbacks with one IDLE cycle between.
    play("b2b_01", 1'b0, 8'h01, 2, 1'b1, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
